// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for NDIG common-anode 7-segment digits
// sharing one hex decoder. A frame-coherent copy of the displayed value is
// held in "active"; new values land in "pending" and are promoted only at
// the frame wrap, so a frame never mixes digits of two different values.
//
// Parameters:
//   NDIG       number of digits scanned (2..8)
//   DIV        display interval per digit in clk cycles (>=2)
//   BLANK_CYC  blanking interval before each digit in clk cycles (>=1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        one-cycle write strobe for value/dp_in
//   value       4*NDIG hex digits, digit 0 in the low nibble
//   dp_in       per-digit decimal point request, active-high
//   deco_in     nibble to the shared hex-to-7-segment decoder
//   an          digit enables, active-low, at most one low
//   dp_n        decimal point, active-low
//   frame_done  one-cycle pulse in the last cycle of a full scan
//
// Build option: SEG_LZB_EN enables leading-zero blanking on digits 1..NDIG-1.
//
// state | meaning
// ------+----------------------------------------------------------
// BLANK | all anodes off for BLANK_CYC cycles before digit idx
// SHOW  | digit idx enabled for DIV cycles; wrap after digit NDIG-1

module seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  output logic [3:0]        deco_in,
  output logic [NDIG-1:0]   an,
  output logic              dp_n,
  output logic              frame_done
);

  localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam int IW   = $clog2(NDIG);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              wrap;

  logic [4*NDIG-1:0] pend_val, act_val;
  logic [NDIG-1:0]   pend_dp, act_dp;
  logic              pend_v;

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;

  assign cur_nib = act_val[{idx, 2'b00} +: 4];
  assign cur_dp  = act_dp[idx];

`ifdef SEG_LZB_EN
  // zero_from[k]: active digits k..NDIG-1 are all zero
  logic [NDIG-1:0] zero_from;

  always_comb begin
    zero_from = '0;
    for (int k = 0; k < NDIG; k++) begin
      zero_from[k] = ~|(act_val >> (4 * k));
    end
  end

  // Digit 0 always shows; a requested decimal point keeps a zero digit visible.
  assign cur_blank = (idx != '0) && zero_from[idx] && !cur_dp;
`else
  assign cur_blank = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    wrap      = 1'b0;
    an        = '1;
    dp_n      = 1'b1;
    deco_in   = cur_nib;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (!cur_blank) begin
          an[idx] = 1'b0;
          dp_n    = ~cur_dp;
        end
        if (cnt == CW'(DIV - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx == IW'(NDIG - 1)) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign frame_done = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // A load coinciding with the wrap edge goes straight to active so it is
  // not left waiting a whole frame in pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      act_val  <= '0;
      act_dp   <= '0;
    end else if (wrap) begin
      pend_v <= 1'b0;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        act_val  <= value;
        act_dp   <= dp_in;
      end else if (pend_v) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend_v   <= 1'b1;
    end
  end

endmodule
